// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC field types, BCD helpers and per-field bounds
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_HOLD = 2'd2,
    ST_RPT  = 2'd3
  } estado_t;

  localparam logic [7:0] SEG_MIN  = 8'h00;
  localparam logic [7:0] SEG_MAX  = 8'h59;
  localparam logic [7:0] MIN_MIN  = 8'h00;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HORA_MIN = 8'h00;
  localparam logic [7:0] HORA_MAX = 8'h23;
  localparam logic [7:0] DIA_MIN  = 8'h01;
  localparam logic [7:0] DIA_MAX  = 8'h31;
  localparam logic [7:0] MES_MIN  = 8'h01;
  localparam logic [7:0] MES_MAX  = 8'h12;
  localparam logic [7:0] ANO_MIN  = 8'h00;
  localparam logic [7:0] ANO_MAX  = 8'h99;

  // Only the low 'digits' nibbles are examined; up to 8 digits supported.
  function automatic logic bcd_valido(input logic [31:0] v, input int unsigned digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(digits) && v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Packed BCD orders like binary when every nibble is valid.
  function automatic logic bcd_en_rango(input logic [31:0] v, input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_paso_wrap.sv
// rtl/bcd_paso_wrap.sv - combinational BCD increment/decrement with MIN/MAX wrap
module bcd_paso_wrap
  import rtc_pkg::*;
#(
  parameter int unsigned           DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]   MIN_VAL = '0,
  parameter logic [4*DIGITS-1:0]   MAX_VAL = {DIGITS{4'h9}}
) (
  input  logic [4*DIGITS-1:0] valor_i,
  input  logic                subir_i,
  output logic [4*DIGITS-1:0] valor_o,
  output logic                acarreo_o
);

  logic       fuera;
  logic       c;
  logic [3:0] nib;

  assign fuera = !(bcd_valido(32'(valor_i), DIGITS) &&
                   bcd_en_rango(32'(valor_i), 32'(MIN_VAL), 32'(MAX_VAL)));

  always_comb begin
    valor_o   = valor_i;
    acarreo_o = 1'b0;
    c         = 1'b1;
    nib       = 4'd0;
    // A corrupted value recovers to the bound in the step direction, no wrap flag.
    if (fuera) begin
      valor_o = subir_i ? MIN_VAL : MAX_VAL;
    end else if (subir_i && valor_i == MAX_VAL) begin
      valor_o   = MIN_VAL;
      acarreo_o = 1'b1;
    end else if (!subir_i && valor_i == MIN_VAL) begin
      valor_o   = MAX_VAL;
      acarreo_o = 1'b1;
    end else begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        nib = valor_i[4*i +: 4];
        if (c) begin
          if (subir_i) begin
            if (nib == 4'd9) begin
              valor_o[4*i +: 4] = 4'd0;
            end else begin
              valor_o[4*i +: 4] = nib + 4'd1;
              c = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              valor_o[4*i +: 4] = 4'd9;
            end else begin
              valor_o[4*i +: 4] = nib - 4'd1;
              c = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/reg_bcd_campo.sv
// rtl/reg_bcd_campo.sv - bounded BCD time/date field with load, step, lockout and auto-repeat
module reg_bcd_campo
  import rtc_pkg::*;
#(
  parameter int unsigned         DIGITS        = 2,
  parameter logic [4*DIGITS-1:0] MIN_VAL       = '0,
  parameter logic [4*DIGITS-1:0] MAX_VAL       = {DIGITS{4'h9}},
  parameter int unsigned         LOCK_CYCLES   = 1048576,
  parameter int unsigned         REPEAT_DELAY  = 0,
  parameter int unsigned         REPEAT_PERIOD = 262144
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                UP,
  input  logic                DOWN,
  input  logic                Modificando,
  input  logic                Actualizar,
  input  logic [4*DIGITS-1:0] DATA_in,
  output logic [4*DIGITS-1:0] DATA_out,
  output logic                CAMBIO,
  output logic                ACARREO,
  output logic                ERROR_CARGA
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned MAX_A = (LOCK_CYCLES > REPEAT_DELAY) ? LOCK_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int unsigned CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = (REPEAT_DELAY == 0) ? '0 : CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  data_q, data_d;
  logic          cambio_q, cambio_d;
  logic          acarreo_q, acarreo_d;
  logic          error_q, error_d;

  logic          paso;
  logic          tecla;
  logic          dir_paso;
  logic          carga_ok;
  logic [W-1:0]  sig_valor;
  logic          sig_wrap;

  // The first step of a press uses the live key; later steps the latched one.
  assign dir_paso = (estado_q == ST_IDLE) ? UP : dir_q;
  assign tecla    = dir_q ? UP : DOWN;
  assign carga_ok = bcd_valido(32'(DATA_in), DIGITS) &&
                    bcd_en_rango(32'(DATA_in), 32'(MIN_VAL), 32'(MAX_VAL));

  bcd_paso_wrap #(
    .DIGITS  (DIGITS),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_paso (
    .valor_i   (data_q),
    .subir_i   (dir_paso),
    .valor_o   (sig_valor),
    .acarreo_o (sig_wrap)
  );

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    data_d    = data_q;
    cambio_d  = 1'b0;
    acarreo_d = 1'b0;
    error_d   = 1'b0;
    paso      = 1'b0;
    if (!Modificando) begin
      estado_d = ST_IDLE;
      cnt_d    = '0;
      if (Actualizar) begin
        if (carga_ok) begin
          data_d = DATA_in;
        end else begin
          data_d  = MIN_VAL;
          error_d = 1'b1;
        end
      end
    end else begin
      case (estado_q)
        ST_IDLE: begin
          if (UP || DOWN) begin
            paso     = 1'b1;
            dir_d    = UP;
            cnt_d    = '0;
            estado_d = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (cnt_q == LOCK_LAST) begin
            cnt_d    = '0;
            estado_d = tecla ? ST_HOLD : ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!tecla) begin
            cnt_d    = '0;
            estado_d = ST_IDLE;
          end else if (REPEAT_DELAY != 0) begin
            if (cnt_q == DELAY_LAST) begin
              paso     = 1'b1;
              cnt_d    = '0;
              estado_d = ST_RPT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RPT: begin
          if (!tecla) begin
            cnt_d    = '0;
            estado_d = ST_IDLE;
          end else if (cnt_q == PERIOD_LAST) begin
            paso  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d    = '0;
          estado_d = ST_IDLE;
        end
      endcase
    end
    if (paso) begin
      data_d    = sig_valor;
      cambio_d  = 1'b1;
      acarreo_d = sig_wrap;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q  <= ST_IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      data_q    <= MIN_VAL;
      cambio_q  <= 1'b0;
      acarreo_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      cambio_q  <= cambio_d;
      acarreo_q <= acarreo_d;
      error_q   <= error_d;
    end
  end

  assign DATA_out    = data_q;
  assign CAMBIO      = cambio_q;
  assign ACARREO     = acarreo_q;
  assign ERROR_CARGA = error_q;

endmodule

// File: tb/tb_reg_bcd_campo.sv
// tb/tb_reg_bcd_campo.sv - vector table with scoreboard for reg_bcd_campo (repeat on and off)
module tb_reg_bcd_campo;

  logic       CLK = 1'b0;
  logic       RST, UP, DOWN, Modificando, Actualizar;
  logic [7:0] DATA_in;
  logic [7:0] d0_out, d1_out;
  logic       c0, a0, e0, c1, a1, e1;

  always #5 CLK = ~CLK;

  reg_bcd_campo #(
    .DIGITS(2), .MIN_VAL(8'h01), .MAX_VAL(8'h12),
    .LOCK_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .CLK(CLK), .RST(RST), .UP(UP), .DOWN(DOWN), .Modificando(Modificando),
    .Actualizar(Actualizar), .DATA_in(DATA_in), .DATA_out(d0_out),
    .CAMBIO(c0), .ACARREO(a0), .ERROR_CARGA(e0)
  );

  reg_bcd_campo #(
    .DIGITS(2), .MIN_VAL(8'h01), .MAX_VAL(8'h12),
    .LOCK_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
  ) dut_nr (
    .CLK(CLK), .RST(RST), .UP(UP), .DOWN(DOWN), .Modificando(Modificando),
    .Actualizar(Actualizar), .DATA_in(DATA_in), .DATA_out(d1_out),
    .CAMBIO(c1), .ACARREO(a1), .ERROR_CARGA(e1)
  );

  typedef struct {
    logic       rst, up, dn, mod, act;
    logic [7:0] din;
    logic [7:0] d0;
    logic       c, a, e;
    logic [7:0] d1;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] d0;
    logic       c, a, e;
    logic [7:0] d1;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic rst, input logic up, input logic dn, input logic mod,
                     input logic act, input logic [7:0] din, input logic [7:0] d0,
                     input logic c, input logic a, input logic e, input logic [7:0] d1,
                     input string name);
    vec_t v;
    v.rst = rst; v.up = up; v.dn = dn; v.mod = mod; v.act = act; v.din = din;
    v.d0 = d0; v.c = c; v.a = a; v.e = e; v.d1 = d1; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t x;
    RST = v.rst; UP = v.up; DOWN = v.dn; Modificando = v.mod; Actualizar = v.act;
    DATA_in = v.din;
    x.d0 = v.d0; x.c = v.c; x.a = v.a; x.e = v.e; x.d1 = v.d1; x.name = v.name;
    sb.push_back(x);
  endtask

  task automatic compare_front();
    exp_t x;
    x = sb.pop_front();
    chk({x.name, ".data"},    d0_out,      x.d0);
    chk({x.name, ".cambio"},  {7'd0, c0},  {7'd0, x.c});
    chk({x.name, ".acarreo"}, {7'd0, a0},  {7'd0, x.a});
    chk({x.name, ".error"},   {7'd0, e0},  {7'd0, x.e});
    chk({x.name, ".data_nr"}, d1_out,      x.d1);
  endtask

  initial begin
    int n;
    RST = 1'b0; UP = 1'b0; DOWN = 1'b0; Modificando = 1'b0; Actualizar = 1'b0;
    DATA_in = 8'h00;

    add(1,0,0,0,0,8'h00, 8'h01,0,0,0, 8'h01, "reset");
    add(0,0,0,0,1,8'h09, 8'h09,0,0,0, 8'h09, "load_09");
    add(0,0,0,0,1,8'h13, 8'h01,0,0,1, 8'h01, "load_13_range");
    add(0,0,0,0,1,8'h1A, 8'h01,0,0,1, 8'h01, "load_1A_nibble");
    add(0,0,0,0,1,8'h09, 8'h09,0,0,0, 8'h09, "reload_09");
    add(0,0,0,0,0,8'h00, 8'h09,0,0,0, 8'h09, "no_strobe");
    add(0,1,0,1,1,8'h05, 8'h10,1,0,0, 8'h10, "up_10_load_ignored");
    add(0,0,0,1,0,8'h00, 8'h10,0,0,0, 8'h10, "lock");
    add(0,1,0,1,0,8'h00, 8'h10,0,0,0, 8'h10, "lock_press_ignored");
    for (int i = 0; i < 2; i++) add(0,0,0,1,0,8'h00, 8'h10,0,0,0, 8'h10, "lock");
    add(0,1,0,1,0,8'h00, 8'h11,1,0,0, 8'h11, "up_11");
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,8'h00, 8'h11,0,0,0, 8'h11, "lock");
    add(0,1,0,1,0,8'h00, 8'h12,1,0,0, 8'h12, "up_12");
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,8'h00, 8'h12,0,0,0, 8'h12, "lock");
    add(0,1,0,1,0,8'h00, 8'h01,1,1,0, 8'h01, "wrap_up");
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,8'h00, 8'h01,0,0,0, 8'h01, "lock");
    add(0,0,1,1,0,8'h00, 8'h12,1,1,0, 8'h12, "wrap_down");
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,8'h00, 8'h12,0,0,0, 8'h12, "lock");
    add(0,0,0,0,1,8'h05, 8'h05,0,0,0, 8'h05, "load_05");
    add(0,1,1,1,0,8'h00, 8'h06,1,0,0, 8'h06, "up_down_prio");
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,8'h00, 8'h06,0,0,0, 8'h06, "lock");
    add(0,0,0,0,1,8'h01, 8'h01,0,0,0, 8'h01, "load_01");
    add(0,1,0,1,0,8'h00, 8'h02,1,0,0, 8'h02, "held_first");
    for (int i = 0; i < 11; i++) add(0,1,0,1,0,8'h00, 8'h02,0,0,0, 8'h02, "held_wait");
    add(0,1,0,1,0,8'h00, 8'h03,1,0,0, 8'h02, "rpt_first");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) add(0,1,0,1,0,8'h00, 8'(3 + k),0,0,0, 8'h02, "rpt_gap");
      add(0,1,0,1,0,8'h00, 8'(4 + k),1,0,0, 8'h02, "rpt_step");
    end
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,8'h00, 8'h06,0,0,0, 8'h02, "released");
    add(0,0,0,0,1,8'h01, 8'h01,0,0,0, 8'h01, "load_01b");
    add(0,1,0,1,0,8'h00, 8'h02,1,0,0, 8'h02, "held_first_b");
    for (int i = 0; i < 11; i++) add(0,1,0,1,0,8'h00, 8'h02,0,0,0, 8'h02, "held_wait_b");
    add(0,1,0,1,0,8'h00, 8'h03,1,0,0, 8'h02, "rpt_first_b");
    add(0,1,0,0,1,8'h07, 8'h07,0,0,0, 8'h07, "mod_drop_load");
    add(0,1,0,1,0,8'h00, 8'h08,1,0,0, 8'h08, "idle_after_drop");
    add(0,0,0,1,0,8'h00, 8'h08,0,0,0, 8'h08, "lock");
    add(1,0,0,1,0,8'h00, 8'h01,0,0,0, 8'h01, "rst_mid_lock");
    add(0,1,0,1,0,8'h00, 8'h02,1,0,0, 8'h02, "press_after_rst");
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,8'h00, 8'h02,0,0,0, 8'h02, "lock");

    @(posedge CLK); #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge CLK); #1;
      compare_front();
    end

    // Hand sequence: measure repeat timing by waiting on CAMBIO with a cycle budget.
    RST = 1'b0; Modificando = 1'b1; Actualizar = 1'b0; UP = 1'b1; DOWN = 1'b0;
    @(posedge CLK); #1;
    chk("hand_first_step", {7'd0, c0}, 8'd1);
    chk("hand_first_data", d0_out, 8'h03);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!c0 && n < 40);
    chk("hand_delay_cycles", 8'(n), 8'd12);
    chk("hand_delay_data", d0_out, 8'h04);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!c0 && n < 40);
    chk("hand_period_cycles", 8'(n), 8'd3);
    chk("hand_period_data", d0_out, 8'h05);
    UP = 1'b0;
    n = 0;
    repeat (8) begin @(posedge CLK); #1; if (c0) n++; end
    chk("hand_release_quiet", 8'(n), 8'd0);
    chk("hand_release_data", d0_out, 8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
